// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory arbiter slice.
//   state_e  - arbiter sequencing states
//   owner_e  - which requester currently owns the memory port
//   LS_*     - funct3 load/store size/sign modes
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    typedef enum logic {
        OWN_CPU,
        OWN_DMA
    } owner_e;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

endpackage

// File: rtl/dmem_if.sv
// dmem_if: request/response port between a memory requester and the arbiter.
//   req/we/addr/wdata/mode : request fields, held stable by the requester until gnt
//   gnt                    : one-cycle pulse when the access is issued or rejected
//   rvalid/rdata           : one-cycle load response
//   err                    : misaligned or illegal access (with gnt for stores, rvalid for loads)
// Modports: master = requester side, slave = arbiter side.
interface dmem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [2:0]        mode;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (
        output req, we, addr, wdata, mode,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata, mode,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/dmem_align_check.sv
// dmem_align_check: combinational legality/alignment check for one access.
//   we      in  1  1=store, 0=load
//   addr_lo in  2  low byte-address bits
//   mode    in  3  funct3 load/store mode
//   ok      out 1  mode legal for the direction and address naturally aligned
module dmem_align_check
    import dmem_pkg::*;
(
    input  logic       we,
    input  logic [1:0] addr_lo,
    input  logic [2:0] mode,
    output logic       ok
);

    logic legal;
    logic aligned;

    always_comb begin
        legal   = 1'b0;
        aligned = 1'b0;
        case (mode)
            LS_B, LS_BU: aligned = 1'b1;
            LS_H, LS_HU: aligned = ~addr_lo[0];
            LS_W:        aligned = (addr_lo == 2'b00);
            default:     aligned = 1'b0;
        endcase
        // Unsigned variants only make sense for loads.
        if (we) begin
            legal = (mode == LS_B) || (mode == LS_H) || (mode == LS_W);
        end else begin
            legal = (mode == LS_B) || (mode == LS_H) || (mode == LS_W) ||
                    (mode == LS_BU) || (mode == LS_HU);
        end
        ok = legal & aligned;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU memory stage
// and a DMA/debug loader, sequencing one access at a time and checking alignment.
//   clk, rst_n        : clock, asynchronous active-low reset
//   cpu (dmem_if)     : CPU request/response port
//   dma (dmem_if)     : DMA request/response port
//   cpu_stall         : high while a CPU request is pending and not completing
//   mem_we/addr/wdata/mode, mem_rdata : data_memory32 connection
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int READ_LAT   = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_if.slave             cpu,
    dmem_if.slave             dma,
    output logic              cpu_stall,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_mode,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int CW = $clog2(READ_LAT + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
    localparam logic [CW-1:0] WAIT_LAST  = CW'(READ_LAT - 1);

    state_e        state_q, state_d;
    owner_e        owner_q, owner_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          err_q, err_d;

    logic              own_we;
    logic [ADDR_W-1:0] own_addr;
    logic [DATA_W-1:0] own_wdata;
    logic [2:0]        own_mode;
    logic              own_ok;
    logic              cpu_done;

    // Requests are held stable until gnt, so the owner's live fields are
    // valid throughout ISSUE without a local copy.
    always_comb begin
        if (owner_q == OWN_DMA) begin
            own_we    = dma.we;
            own_addr  = dma.addr;
            own_wdata = dma.wdata;
            own_mode  = dma.mode;
        end else begin
            own_we    = cpu.we;
            own_addr  = cpu.addr;
            own_wdata = cpu.wdata;
            own_mode  = cpu.mode;
        end
    end

    dmem_align_check u_align (
        .we      (own_we),
        .addr_lo (own_addr[1:0]),
        .mode    (own_mode),
        .ok      (own_ok)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= OWN_CPU;
            starve_q <= '0;
            wait_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
            wait_q   <= wait_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        starve_d   = starve_q;
        wait_d     = wait_q;
        err_d      = err_q;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_mode   = '0;
        cpu.gnt    = 1'b0;
        cpu.rvalid = 1'b0;
        cpu.rdata  = '0;
        cpu.err    = 1'b0;
        dma.gnt    = 1'b0;
        dma.rvalid = 1'b0;
        dma.rdata  = '0;
        dma.err    = 1'b0;
        cpu_done   = 1'b0;

        case (state_q)
            IDLE: begin
                // CPU has priority unless DMA has been starved long enough.
                if (cpu.req || dma.req) begin
                    if (dma.req && (!cpu.req || (starve_q == STARVE_TOP))) begin
                        owner_d = OWN_DMA;
                    end else begin
                        owner_d = OWN_CPU;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                mem_we    = own_we & own_ok;
                mem_addr  = own_addr;
                mem_wdata = own_wdata;
                mem_mode  = own_mode;
                err_d     = ~own_ok;
                if (owner_q == OWN_CPU) begin
                    cpu.gnt  = 1'b1;
                    cpu.err  = own_we & ~own_ok;
                    cpu_done = own_we;
                    if (dma.req) begin
                        starve_d = (starve_q == STARVE_TOP) ? STARVE_TOP : starve_q + SW'(1);
                    end else begin
                        starve_d = '0;
                    end
                end else begin
                    dma.gnt  = 1'b1;
                    dma.err  = own_we & ~own_ok;
                    starve_d = '0;
                end
                // Rejected loads never touch memory, so they answer immediately.
                if (own_we) begin
                    state_d = IDLE;
                end else if (!own_ok || (READ_LAT == 1)) begin
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                    wait_d  = CW'(1);
                end
            end
            WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = RESP;
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
            RESP: begin
                if (owner_q == OWN_CPU) begin
                    cpu.rvalid = 1'b1;
                    cpu.rdata  = err_q ? '0 : mem_rdata;
                    cpu.err    = err_q;
                    cpu_done   = 1'b1;
                end else begin
                    dma.rvalid = 1'b1;
                    dma.rdata  = err_q ? '0 : mem_rdata;
                    dma.err    = err_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        cpu_stall = cpu.req & ~cpu_done;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter with a behavioural
// data memory (READ_LAT pipeline) and a transaction-level reference model.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int RL   = 3;
    localparam int SMAX = 4;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  mode;
    } op_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_clear;
    logic        cpu_stall;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [2:0]  mem_mode;

    dmem_if #(.ADDR_W(32), .DATA_W(32)) cpu_if ();
    dmem_if #(.ADDR_W(32), .DATA_W(32)) dma_if ();

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .READ_LAT   (RL),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu       (cpu_if),
        .dma       (dma_if),
        .cpu_stall (cpu_stall),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_mode  (mem_mode),
        .mem_rdata (mem_rdata)
    );

    function automatic logic [7:0] initByte(int i);
        return 8'(i * 29 + 7);
    endfunction

    // Behavioural data memory: 256 bytes, little-endian, READ_LAT-cycle read.
    logic [7:0] mem_arr [256];
    logic [7:0] pipe_addr [RL];
    logic [2:0] pipe_mode [RL];
    logic [7:0] rd_a, rb0, rb1, rb2, rb3;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= initByte(i);
        end else if (mem_we) begin
            mem_arr[mem_addr[7:0]] <= mem_wdata[7:0];
            if (mem_mode[1:0] != 2'b00) mem_arr[mem_addr[7:0] + 8'd1] <= mem_wdata[15:8];
            if (mem_mode[1:0] == 2'b10) begin
                mem_arr[mem_addr[7:0] + 8'd2] <= mem_wdata[23:16];
                mem_arr[mem_addr[7:0] + 8'd3] <= mem_wdata[31:24];
            end
        end
        pipe_addr[0] <= mem_addr[7:0];
        pipe_mode[0] <= mem_mode;
        for (int i = 1; i < RL; i++) begin
            pipe_addr[i] <= pipe_addr[i-1];
            pipe_mode[i] <= pipe_mode[i-1];
        end
    end

    always_comb begin
        mem_rdata = 32'h0;
        rd_a = pipe_addr[RL-1];
        rb0  = mem_arr[rd_a];
        rb1  = mem_arr[rd_a + 8'd1];
        rb2  = mem_arr[rd_a + 8'd2];
        rb3  = mem_arr[rd_a + 8'd3];
        case (pipe_mode[RL-1])
            3'b000:  mem_rdata = {{24{rb0[7]}}, rb0};
            3'b001:  mem_rdata = {{16{rb1[7]}}, rb1, rb0};
            3'b010:  mem_rdata = {rb3, rb2, rb1, rb0};
            3'b100:  mem_rdata = {24'h0, rb0};
            3'b101:  mem_rdata = {16'h0, rb1, rb0};
            default: mem_rdata = 32'h0;
        endcase
    end

    // Reference model state.
    logic [7:0] ref_mem [256];
    int         starve_ref;
    op_t        cpu_op, dma_op;
    bit         cpu_pend, dma_pend;
    int         checks = 0;
    int         passes = 0;

    function automatic int opSize(logic [2:0] mode);
        return (mode[1:0] == 2'b00) ? 1 : ((mode[1:0] == 2'b01) ? 2 : 4);
    endfunction

    function automatic bit refOk(op_t op);
        bit legal;
        if (op.we) legal = (op.mode == 3'b000) || (op.mode == 3'b001) || (op.mode == 3'b010);
        else       legal = (op.mode == 3'b000) || (op.mode == 3'b001) || (op.mode == 3'b010) ||
                           (op.mode == 3'b100) || (op.mode == 3'b101);
        return legal && ((op.addr % opSize(op.mode)) == 0);
    endfunction

    function automatic logic [31:0] refLoad(op_t op);
        logic [31:0] val;
        int          size;
        size = opSize(op.mode);
        val  = 32'h0;
        for (int k = 0; k < size; k++) val = val | (32'(ref_mem[8'(op.addr + k)]) << (8 * k));
        if (!op.mode[2] && size < 4 && val[8*size-1]) val = val | ~((32'h1 << (8 * size)) - 32'h1);
        return val;
    endfunction

    task automatic refStore(input op_t op);
        for (int k = 0; k < opSize(op.mode); k++) ref_mem[8'(op.addr + k)] = 8'(op.wdata >> (8 * k));
    endtask

    function automatic op_t mkOp(logic we, logic [31:0] addr, logic [31:0] wdata, logic [2:0] mode);
        op_t op;
        op.we = we; op.addr = addr; op.wdata = wdata; op.mode = mode;
        return op;
    endfunction

    function automatic op_t genOp();
        op_t op;
        int  r;
        op.we = 1'($urandom_range(0, 1));
        r = $urandom_range(0, 9);
        case (r)
            0:       op.mode = 3'b011;
            1:       op.mode = 3'b110;
            2, 3:    op.mode = 3'b000;
            4:       op.mode = 3'b100;
            5, 6:    op.mode = 3'b010;
            7:       op.mode = 3'b001;
            default: op.mode = 3'b101;
        endcase
        op.addr = 32'($urandom_range(0, 255));
        if ($urandom_range(0, 3) != 0) op.addr = op.addr & ~32'(opSize(op.mode) - 1);
        op.wdata = $urandom;
        return op;
    endfunction

    task automatic applyStimulus();
        cpu_if.req   = cpu_pend;
        cpu_if.we    = cpu_op.we;
        cpu_if.addr  = cpu_op.addr;
        cpu_if.wdata = cpu_op.wdata;
        cpu_if.mode  = cpu_op.mode;
        dma_if.req   = dma_pend;
        dma_if.we    = dma_op.we;
        dma_if.addr  = dma_op.addr;
        dma_if.wdata = dma_op.wdata;
        dma_if.mode  = dma_op.mode;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One arbitration round starting in IDLE: issue, optional load response.
    // hold_cpu keeps cpu_req high through a CPU load until its rvalid cycle.
    task automatic doRound(input bit hold_cpu, output bit dma_won,
                           output logic [31:0] got_rdata, output logic got_err);
        op_t         op;
        bit          ok;
        bit          cpu_owner;
        logic [31:0] exp_load;
        int          lat;
        applyStimulus();
        @(negedge clk);
        checkOutput("idle_gnt", {30'd0, cpu_if.gnt, dma_if.gnt}, 32'd0);
        checkOutput("idle_mem_we", 32'(mem_we), 32'd0);
        checkOutput("idle_stall", 32'(cpu_stall), 32'(cpu_pend));
        dma_won   = dma_pend && (!cpu_pend || starve_ref == SMAX);
        cpu_owner = !dma_won;
        op        = dma_won ? dma_op : cpu_op;
        ok        = refOk(op);
        exp_load  = ok ? refLoad(op) : 32'h0;
        got_rdata = 32'h0;

        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("cpu_gnt", 32'(cpu_if.gnt), 32'(cpu_owner));
        checkOutput("dma_gnt", 32'(dma_if.gnt), 32'(dma_won));
        checkOutput("issue_mem_we", 32'(mem_we), 32'(op.we && ok));
        checkOutput("issue_mem_addr", mem_addr, op.addr);
        checkOutput("issue_mem_mode", 32'(mem_mode), 32'(op.mode));
        if (op.we) checkOutput("issue_mem_wdata", mem_wdata, op.wdata);
        got_err = cpu_owner ? cpu_if.err : dma_if.err;
        checkOutput("gnt_err", 32'(got_err), 32'(op.we && !ok));
        checkOutput("issue_stall", 32'(cpu_stall), 32'(cpu_pend && !(cpu_owner && op.we)));

        if (dma_won || !dma_pend) starve_ref = 0;
        else if (starve_ref < SMAX) starve_ref++;
        if (op.we && ok) refStore(op);

        @(posedge clk); #1;
        if (dma_won) begin
            dma_pend = 0; dma_if.req = 1'b0;
        end else if (!(hold_cpu && !op.we)) begin
            cpu_pend = 0; cpu_if.req = 1'b0;
        end

        if (!op.we) begin
            lat = ok ? RL : 1;
            for (int k = 1; k <= lat; k++) begin
                if (k > 1) begin @(posedge clk); #1; end
                @(negedge clk);
                checkOutput("cpu_rvalid", 32'(cpu_if.rvalid), 32'(cpu_owner && k == lat));
                checkOutput("dma_rvalid", 32'(dma_if.rvalid), 32'(dma_won && k == lat));
                checkOutput("post_issue_mem_we", 32'(mem_we), 32'd0);
                checkOutput("load_stall", 32'(cpu_stall), 32'(cpu_if.req && !(cpu_owner && k == lat)));
                if (k == lat) begin
                    got_rdata = cpu_owner ? cpu_if.rdata : dma_if.rdata;
                    got_err   = cpu_owner ? cpu_if.err : dma_if.err;
                    checkOutput("resp_rdata", got_rdata, exp_load);
                    checkOutput("resp_err", 32'(got_err), 32'(!ok));
                    checkOutput("other_rdata", cpu_owner ? dma_if.rdata : cpu_if.rdata, 32'h0);
                end
            end
            @(posedge clk); #1;
            if (cpu_owner && hold_cpu) begin
                cpu_pend = 0; cpu_if.req = 1'b0;
            end
        end
    endtask

    initial begin
        bit          won;
        logic [31:0] rd;
        logic        er;

        // Reset with a CPU store already requesting.
        rst_n      = 1'b0;
        mem_clear  = 1'b1;
        starve_ref = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = initByte(i);
        cpu_op   = mkOp(1'b1, 32'h10, 32'hDEADBEEF, LS_W);
        dma_op   = mkOp(1'b0, 32'h0, 32'h0, LS_W);
        cpu_pend = 1;
        dma_pend = 0;
        applyStimulus();
        @(posedge clk); #1;
        mem_clear = 1'b0;
        @(negedge clk);
        checkOutput("rst_gnt", {30'd0, cpu_if.gnt, dma_if.gnt}, 32'd0);
        checkOutput("rst_rvalid", {30'd0, cpu_if.rvalid, dma_if.rvalid}, 32'd0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_cpu_rdata", cpu_if.rdata, 32'd0);
        checkOutput("rst_stall", 32'(cpu_stall), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // SW then LW at 0x10.
        doRound(0, won, rd, er);
        checkOutput("sw_err", 32'(er), 32'd0);
        cpu_op = mkOp(1'b0, 32'h10, 32'h0, LS_W); cpu_pend = 1;
        doRound(0, won, rd, er);
        checkOutput("lw_rdata", rd, 32'hDEADBEEF);
        checkOutput("lw_err", 32'(er), 32'd0);

        // Both ports continuously requesting: four CPU grants, then one DMA.
        for (int i = 0; i < 10; i++) begin
            if (!cpu_pend) begin cpu_op = genOp(); cpu_pend = 1; end
            if (!dma_pend) begin dma_op = genOp(); dma_pend = 1; end
            doRound(0, won, rd, er);
            checkOutput("starve_pattern", 32'(won), 32'((i % 5) == 4));
        end
        for (int n = 0; n < 4 && (cpu_pend || dma_pend); n++) doRound(0, won, rd, er);

        // Misaligned and illegal accesses.
        cpu_op = mkOp(1'b0, 32'h13, 32'h0, LS_W); cpu_pend = 1;
        doRound(0, won, rd, er);
        checkOutput("mis_lw_err", 32'(er), 32'd1);
        checkOutput("mis_lw_rdata", rd, 32'h0);
        cpu_op = mkOp(1'b1, 32'h21, 32'h5555, LS_H); cpu_pend = 1;
        doRound(0, won, rd, er);
        checkOutput("mis_sh_err", 32'(er), 32'd1);
        cpu_op = mkOp(1'b0, 32'h20, 32'h0, 3'b011); cpu_pend = 1;
        doRound(0, won, rd, er);
        checkOutput("ill_load_err", 32'(er), 32'd1);

        // Reset during a store issue: write must not land.
        cpu_op = mkOp(1'b1, 32'h40, 32'h12345678, LS_W); cpu_pend = 1;
        applyStimulus();
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("rst_issue_we_before", 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_issue_we_after", 32'(mem_we), 32'd0);
        checkOutput("rst_issue_gnt", 32'(cpu_if.gnt), 32'd0);
        cpu_pend = 0; cpu_if.req = 1'b0; starve_ref = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cpu_op = mkOp(1'b0, 32'h40, 32'h0, LS_W); cpu_pend = 1;
        doRound(0, won, rd, er);

        // Reset while a load waits for memory: no response afterwards.
        cpu_op = mkOp(1'b0, 32'h44, 32'h0, LS_W); cpu_pend = 1;
        applyStimulus();
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("wait_load_gnt", 32'(cpu_if.gnt), 32'd1);
        @(posedge clk); #1;
        cpu_pend = 0; cpu_if.req = 1'b0;
        @(negedge clk);
        checkOutput("wait_no_rvalid", 32'(cpu_if.rvalid), 32'd0);
        #1;
        rst_n = 1'b0;
        starve_ref = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            checkOutput("after_rst_rvalid", {30'd0, cpu_if.rvalid, dma_if.rvalid}, 32'd0);
            @(posedge clk); #1;
        end
        cpu_op = mkOp(1'b0, 32'h44, 32'h0, LS_W); cpu_pend = 1;
        doRound(0, won, rd, er);

        // DMA byte store, then CPU LBU holding its request until rvalid.
        dma_op = mkOp(1'b1, 32'h5, 32'hAB, LS_B); dma_pend = 1;
        doRound(0, won, rd, er);
        checkOutput("dma_sb_won", 32'(won), 32'd1);
        cpu_op = mkOp(1'b0, 32'h5, 32'h0, LS_BU); cpu_pend = 1;
        doRound(1, won, rd, er);
        checkOutput("lbu_rdata", rd, 32'h000000AB);

        // Randomised traffic from both ports.
        for (int i = 0; i < 40; i++) begin
            if (!cpu_pend && $urandom_range(0, 9) < 6) begin cpu_op = genOp(); cpu_pend = 1; end
            if (!dma_pend && $urandom_range(0, 9) < 6) begin dma_op = genOp(); dma_pend = 1; end
            if (!cpu_pend && !dma_pend) begin cpu_op = genOp(); cpu_pend = 1; end
            doRound(0, won, rd, er);
        end
        for (int n = 0; n < 4 && (cpu_pend || dma_pend); n++) doRound(0, won, rd, er);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
